// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate_sweep truth-table tester.
package gate_sweep_pkg;

  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  localparam logic [3:0] EXPECT_NOR = 4'b0001;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_DRIVE  = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/sweep_settle_cnt.sv
// Settle down-counter: loads a hold count, decrements to zero and stops there.
module sweep_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_sweep.sv
// gate_sweep: applies vectors 00..11 to a 2-input gate and captures its truth table.
// Define GATE_SWEEP_ERRCNT_EN to add the saturating err_cnt output.
//
// state  | meaning
// IDLE   | outputs low, waiting for start
// DRIVE  | vector applied, settle count running down
// SAMPLE | final hold cycle, c_in captured at its closing edge
// DONE   | one-cycle result strobe, then back to IDLE
module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = EXPECT_NOR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic       pass
`ifdef GATE_SWEEP_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_truth;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_last;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_busy;
  logic [3:0]       w_truth_nxt;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_last     = &r_idx;
  assign w_cnt_load = w_start_ok || ((r_state == S_SAMPLE) && !w_last);
  assign w_cnt_dec  = (r_state == S_DRIVE);
  assign w_busy     = (r_state == S_DRIVE) || (r_state == S_SAMPLE);

  // Truth table as it will look once the current vector's sample lands.
  always_comb begin
    w_truth_nxt        = r_truth;
    w_truth_nxt[r_idx] = c_in;
  end

  sweep_settle_cnt #(
    .W (CNT_W)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_truth <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_idx   <= '0;
            r_truth <= '0;
            r_pass  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (w_cnt_zero) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_truth <= w_truth_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            // Resolve pass here so it is already valid during the DONE strobe.
            r_pass  <= (w_truth_nxt == EXPECT);
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_DRIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a_out = w_busy & r_idx[1];
  assign b_out = w_busy & r_idx[0];
  assign busy  = w_busy;
  assign done  = (r_state == S_DONE);
  assign truth = r_truth;
  assign pass  = r_pass;

`ifdef GATE_SWEEP_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_DONE) && !r_pass && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
